// File: rtl/sll32_seq.sv
// Multicycle 32-bit logical left shifter, one power-of-two stage (16,8,4,2,1) per clock.
// Reports whether any 1 bit was shifted out past bit 31; start/busy/done handshake.
module sll32_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [4:0]  shiftamt,
  output logic [31:0] Out,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] w;
  logic [4:0]  s;
  logic        v;
  logic [2:0]  k;

  logic        accept;
  logic [4:0]  stage_amt;
  logic [31:0] w_shift;
  logic [31:0] lost_mask;
  logic        lost_any;
  logic [31:0] w_nxt;
  logic        v_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (k == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage k shifts by 2^k; the bits pushed past bit 31 are the top 2^k bits of w.
  always_comb begin
    stage_amt = 5'd1 << k;
    w_shift   = w << stage_amt;
    lost_mask = ~(32'hFFFF_FFFF >> stage_amt);
    lost_any  = |(w & lost_mask);
    w_nxt     = s[k] ? w_shift : w;
    v_nxt     = v | (s[k] & lost_any);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w        <= 32'd0;
      s        <= 5'd0;
      v        <= 1'b0;
      k        <= 3'd4;
      Out      <= 32'd0;
      overflow <= 1'b0;
    end else if (accept) begin
      w <= A;
      s <= shiftamt;
      v <= 1'b0;
      k <= 3'd4;
    end else if (state == SHIFT) begin
      w <= w_nxt;
      v <= v_nxt;
      if (k == 3'd0) begin
        Out      <= w_nxt;
        overflow <= v_nxt;
      end else begin
        k <= k - 3'd1;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
